mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write).
- Sits between the pipelined datapath/controller and the memory model.
- Serialises accesses with a request/done handshake and drives stall flags into the hazard logic.
- Provides fetch-starvation protection and a memory-timeout watchdog.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win; 0 = strict data priority
MAX_WAIT, 64, cycles without mem_ready before a busy access is aborted (≥1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data; valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  data read result; valid while dm_done=1
dm_done  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request; held until mem_ready or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completes current access this cycle
mem_rdata  in  DATA_W  memory read data; valid with mem_ready
stall_if  out  1  if_req & ~if_done
stall_dm  out  1  dm_req & ~dm_done
busy  out  1  FSM not in IDLE
timeout_err  out  1  sticky; set on any watchdog abort

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE; starve_cnt=0; wait_cnt=0.
  - All registered outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, timeout_err.
  - Reset mid-access abandons the access silently; no done pulse.
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- IDLE arbitration, single request pending: that request wins.
- IDLE arbitration, both pending: data wins unless STARVE_LIMIT≠0 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - +1 when data wins while if_req=1.
  - Cleared when fetch wins.
  - Saturates at STARVE_LIMIT.
- Grant (IDLE → IBUSY/DBUSY): next cycle, mem_req=1 and mem_addr/mem_we/mem_wdata are registered copies of the winner's inputs. mem_we=0 for fetch.
- Memory outputs are held constant throughout the busy state.
- IBUSY/DBUSY with mem_ready=1:
  - Next cycle: mem_req=0; FSM=RESP; matching done=1; matching rdata=registered mem_rdata.
  - On writes, dm_rdata=0.
- RESP:
  - Exactly one cycle; no arbitration; returns to IDLE.
  - A req still high in RESP is the completed transaction, not a new one. The requester must drop req, or present a new transaction starting the following cycle.
- Done pulses are exactly one cycle wide. if_done and dm_done are never asserted together.
- Latency: request sampled in IDLE at cycle t → mem_req at t+1 → mem_ready at t+k (k≥1) → done at t+k+1 → IDLE at t+k+2.
- mem_ready in IDLE or RESP is ignored.
- Watchdog:
  - wait_cnt clears on entry to IBUSY/DBUSY and increments each busy cycle without mem_ready.
  - When wait_cnt reaches MAX_WAIT, the access aborts: mem_req=0, done pulse with rdata=0, timeout_err=1 (sticky until reset), FSM=RESP.
  - mem_ready in the same cycle as the threshold takes precedence: normal completion, no error.
- Requests deasserted while busy are protocol violations. The arbiter still completes the access and pulses done.
- stall_if and stall_dm are combinational from inputs and registered done flags.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_IBUSY, ARB_DBUSY, ARB_RESP}.
  - typedef enum logic owner_t {OWN_IF, OWN_DM}.
  - Default widths as localparams.
- Sub-module arb_watchdog:
  - Parameter MAX_WAIT.
  - Inputs clk, reset, start, tick_en, ready.
  - Output expire.
  - Counter width $clog2(MAX_WAIT+1).
- Everything else lives in mem_port_arbiter.

Test Plan:
- Fetch only: if_req, if_addr=0x0000_0040; mem_ready one cycle after mem_req, mem_rdata=0x2002_0005 → mem_addr=0x40, mem_we=0; if_done one cycle with if_rdata=0x2002_0005; done 3 cycles after request sampled; dm_done stays 0.
- Data write: dm_req, dm_we=1, dm_addr=0x54, dm_wdata=0xDEAD_BEEF; memory stalls 3 cycles → mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; dm_done pulse; dm_rdata=0; stall_dm high until dm_done.
- Contention, STARVE_LIMIT=4: if_req held and dm_req re-asserted after every dm_done → grants D,D,D,D,I. The 5th grant goes to fetch; starve_cnt returns to 0.
- Contention, STARVE_LIMIT=0: same stimulus → fetch never granted while dm_req keeps being re-asserted; if_done only after dm_req stops.
- Timeout: MAX_WAIT=8; dm read with mem_ready never asserted → abort after 8 busy cycles; dm_done with dm_rdata=0; timeout_err=1 and stays 1 through subsequent normal accesses.
- Reset mid-access: assert reset (0) during DBUSY → all outputs 0 immediately; no done pulse; after release, a fresh if_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the unified-memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int MAX_WAIT_DEF     = 64;
    typedef enum logic [1:0] {ARB_IDLE, ARB_IBUSY, ARB_DBUSY, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: counts busy cycles without mem_ready and flags the cycle an access must abort.
module arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick_en,
    input  logic ready,
    output logic expire
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // expire fires during the MAX_WAIT-th idle busy cycle so the abort lands on the next edge
    assign expire = tick_en && !ready && cnt_q == LAST;
    assign cnt_d  = start ? '0 : (tick_en && !ready) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one memory port with
// starvation protection for fetch and a watchdog that aborts hung accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MAX_WAIT     = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              busy,
    output logic              timeout_err
);
    localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d, rd;
    logic              if_done_q, if_done_d, dm_done_q, dm_done_d, terr_q, terr_d;
    logic              expire, in_busy, grant;
    owner_t            win;
    assign in_busy = state_q == ARB_IBUSY || state_q == ARB_DBUSY;
    assign grant   = state_q == ARB_IDLE && (if_req || dm_req);
    assign win     = (dm_req && !(if_req && STARVE_LIMIT != 0 && starve_q == LIM)) ? OWN_DM : OWN_IF;
    // aborted accesses and completed writes return zero data
    assign rd      = (mem_ready && !mem_we_q) ? mem_rdata : '0;
    arb_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
        .clk(clk), .reset(reset), .start(grant), .tick_en(in_busy), .ready(mem_ready), .expire(expire)
    );
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        terr_d      = terr_q;
        case (state_q)
            ARB_IDLE: if (grant) begin
                state_d     = win == OWN_DM ? ARB_DBUSY : ARB_IBUSY;
                mem_req_d   = 1'b1;
                mem_we_d    = win == OWN_DM && dm_we;
                mem_addr_d  = win == OWN_DM ? dm_addr : if_addr;
                mem_wdata_d = win == OWN_DM ? dm_wdata : '0;
                starve_d    = win == OWN_IF ? '0 : (if_req && starve_q != LIM) ? starve_q + 1'b1 : starve_q;
            end
            ARB_IBUSY, ARB_DBUSY: if (mem_ready || expire) begin
                state_d    = ARB_RESP;
                mem_req_d  = 1'b0;
                if_done_d  = state_q == ARB_IBUSY;
                dm_done_d  = state_q == ARB_DBUSY;
                if_rdata_d = state_q == ARB_IBUSY ? rd : if_rdata_q;
                dm_rdata_d = state_q == ARB_DBUSY ? rd : dm_rdata_q;
                terr_d     = terr_q || !mem_ready;
            end
            default: state_d = ARB_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            terr_q      <= terr_d;
        end
    end
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign timeout_err = terr_q;
    assign busy        = state_q != ARB_IDLE;
    assign stall_if    = if_req && !if_done_q;
    assign stall_dm    = dm_req && !dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench; instance a has STARVE_LIMIT=4, instance b has 0.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    logic        if_req_a = 0, dm_req_a = 0, if_req_b = 0, dm_req_b = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    logic        mem_ready_a = 0, mem_ready_b = 0;
    logic [31:0] mem_rdata_a = 0, mem_rdata_b = 0;
    logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b;
    logic        if_done_a, dm_done_a, mem_req_a, mem_we_a, stall_if_a, stall_dm_a, busy_a, terr_a;
    logic        if_done_b, dm_done_b, mem_req_b, mem_we_b, stall_if_b, stall_dm_b, busy_b, terr_b;
    int checks = 0, failures = 0, lat = 1, n = 0;
    bit mem_en = 1;
    typedef struct {logic dm; logic [31:0] rdata;} exp_t;
    exp_t sb[$];
    mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(8)) u_a (
        .clk(clk), .reset(reset), .if_req(if_req_a), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_done(if_done_a),
        .dm_req(dm_req_a), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata_a), .dm_done(dm_done_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ready(mem_ready_a),
        .mem_rdata(mem_rdata_a), .stall_if(stall_if_a), .stall_dm(stall_dm_a), .busy(busy_a), .timeout_err(terr_a)
    );
    mem_port_arbiter #(.STARVE_LIMIT(0), .MAX_WAIT(8)) u_b (
        .clk(clk), .reset(reset), .if_req(if_req_b), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_done(if_done_b),
        .dm_req(dm_req_b), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata_b), .dm_done(dm_done_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ready(mem_ready_b),
        .mem_rdata(mem_rdata_b), .stall_if(stall_if_b), .stall_dm(stall_dm_b), .busy(busy_b), .timeout_err(terr_b)
    );
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a == 32'h40 ? 32'h2002_0005 : a ^ 32'h5A5A_0000;
    endfunction
    // memory a answers lat cycles after mem_req rises; memory b answers at once
    initial begin
        int wc;
        wc = 0;
        forever begin
            @(negedge clk);
            mem_ready_a = 1'b0;
            if (!mem_req_a) wc = 0;
            else begin
                if (mem_en && wc == lat) begin
                    mem_ready_a = 1'b1;
                    mem_rdata_a = rd_of(mem_addr_a);
                end
                wc++;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        mem_ready_b = mem_req_b;
        mem_rdata_b = rd_of(mem_addr_b);
    end
    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic wait_done(input string tag, input int start, output int cnt);
        exp_t e;
        cnt = start;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(if_done_a || dm_done_a) && cnt < 40);
        chk({tag, "_timeout"}, cnt < 40, 1);
        if (cnt < 40) begin
            chk({tag, "_excl"}, if_done_a & dm_done_a, 0);
            chk({tag, "_sb"}, sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_owner"}, dm_done_a, e.dm);
                chk({tag, "_rdata"}, e.dm ? dm_rdata_a : if_rdata_a, e.rdata);
            end
        end
    endtask
    initial begin
        int dms, ifs;
        repeat (2) @(negedge clk);
        chk("rst_a", {mem_req_a, mem_we_a, if_done_a, dm_done_a, busy_a, terr_a, mem_addr_a, mem_wdata_a}, 0);
        chk("rst_a_rd", {if_rdata_a, dm_rdata_a}, 0);
        chk("rst_b", {mem_req_b, if_done_b, dm_done_b, busy_b, terr_b, mem_addr_b}, 0);
        reset = 1'b1;
        @(negedge clk);
        if_addr = 32'h40; if_req_a = 1'b1; sb.push_back('{1'b0, 32'h2002_0005});
        @(negedge clk);
        chk("if_mem", {mem_req_a, mem_we_a, mem_addr_a}, {1'b1, 1'b0, 32'h40});
        wait_done("if", 1, n);
        if_req_a = 1'b0;
        chk("if_lat", n, 3);
        @(negedge clk);
        chk("if_pulse", {if_done_a, dm_done_a, busy_a}, 0);
        lat = 3; dm_we = 1'b1; dm_addr = 32'h54; dm_wdata = 32'hDEAD_BEEF; dm_req_a = 1'b1;
        sb.push_back('{1'b1, 32'h0});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("wr_hold%0d", i), {mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, stall_dm_a},
                {1'b1, 1'b1, 32'h54, 32'hDEAD_BEEF, 1'b1});
        end
        wait_done("wr", 4, n);
        chk("wr_stall", stall_dm_a, 0);
        dm_req_a = 1'b0;
        chk("wr_lat", n, 5);
        lat = 1; dm_we = 1'b0;
        @(negedge clk);
        dm_addr = 32'h100; if_addr = 32'h200;
        for (int r = 0; r < 2; r++) begin
            repeat (4) sb.push_back('{1'b1, rd_of(32'h100)});
            sb.push_back('{1'b0, rd_of(32'h200)});
        end
        if_req_a = 1'b1; dm_req_a = 1'b1;
        for (int g = 0; g < 10; g++) wait_done($sformatf("cont%0d", g), 0, n);
        if_req_a = 1'b0; dm_req_a = 1'b0;
        sb.delete();
        @(negedge clk);
        dms = 0; ifs = 0;
        if_req_b = 1'b1; dm_req_b = 1'b1;
        repeat (30) begin
            @(negedge clk);
            dms += int'(dm_done_b);
            ifs += int'(if_done_b);
        end
        chk("s0_dm_many", dms >= 8, 1);
        chk("s0_if_none", ifs, 0);
        n = 0;
        while (!dm_done_b && n < 10) begin @(negedge clk); n++; end
        dm_req_b = 1'b0;
        n = 0;
        while (!if_done_b && n < 10) begin @(negedge clk); n++; end
        chk("s0_if_late", {if_done_b, if_rdata_b}, {1'b1, rd_of(32'h200)});
        if_req_b = 1'b0;
        @(negedge clk);
        mem_en = 1'b0; dm_addr = 32'h80; dm_req_a = 1'b1; sb.push_back('{1'b1, 32'h0});
        wait_done("to", 0, n);
        dm_req_a = 1'b0;
        chk("to_lat", n, 9);
        chk("to_err", {terr_a, mem_req_a}, {1'b1, 1'b0});
        mem_en = 1'b1;
        @(negedge clk);
        if_addr = 32'h40; if_req_a = 1'b1; sb.push_back('{1'b0, 32'h2002_0005});
        wait_done("post", 0, n);
        if_req_a = 1'b0;
        chk("post_err", terr_a, 1);
        @(negedge clk);
        mem_en = 1'b0; dm_addr = 32'h60; dm_req_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_busy", {busy_a, mem_req_a}, {1'b1, 1'b1});
        reset = 1'b0;
        #1;
        chk("mid_rst", {mem_req_a, mem_we_a, mem_addr_a, busy_a, terr_a, if_done_a, dm_done_a, dm_rdata_a}, 0);
        dm_req_a = 1'b0; mem_en = 1'b1;
        @(negedge clk);
        chk("mid_nodone", {dm_done_a, if_done_a}, 0);
        reset = 1'b1;
        @(negedge clk);
        if_req_a = 1'b1; sb.push_back('{1'b0, 32'h2002_0005});
        wait_done("fresh", 0, n);
        if_req_a = 1'b0;
        chk("fresh_lat", n, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
